sram8_bus_responder: RTL and testbench

// Target (responder) end of the processor memory bus (sel/addr/we/wr_mask/data/ack).

---
 rtl/sram8_bus_responder.sv | 149 ++++++++++++++
 tb/tb_sram8_bus_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sram8_bus_responder.sv
// Bus responder that serves 32-bit word reads and writes from an 8-bit asynchronous SRAM,
// one byte per access, lowest enabled lane first, with a one-cycle ack on completion.
module sram8_bus_responder #(
    parameter int SRAM_AW       = 19,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_ni,
    input  logic               ce_i,
    input  logic               sel_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic [3:0]         wr_mask_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    output logic               ack_o,
    output logic               overrun_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    input  logic [7:0]         sram_d_i,
    output logic [7:0]         sram_d_o,
    output logic               sram_d_oe_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    logic [1:0]         state_q;
    logic [SRAM_AW-3:0] word_q;
    logic               we_q;
    logic [3:0]         pend_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [1:0]         k_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [3:0]         lanes_req;
    logic [1:0]         k_start;
    logic [1:0]         k_next;
    logic               unused_addr;

    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [1:0] k);
        return d[{k, 3'b000} +: 8];
    endfunction

    always_comb begin
        lanes_req = we_i ? wr_mask_i : 4'hF;
        k_start   = lowest_lane(lanes_req);
        k_next    = lowest_lane(pend_q);
    end

    assign unused_addr = ^{addr_i[31:SRAM_AW], addr_i[1:0]};

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            word_q      <= '0;
            we_q        <= 1'b0;
            pend_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            data_o      <= '0;
            ack_o       <= 1'b0;
            overrun_o   <= 1'b0;
            sram_addr_o <= '0;
            sram_d_o    <= '0;
            sram_d_oe_o <= 1'b0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
        end else if (ce_i) begin
            ack_o     <= 1'b0;
            overrun_o <= sel_i && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (sel_i) begin
                        word_q  <= addr_i[SRAM_AW-1:2];
                        we_q    <= we_i;
                        wdata_q <= data_i;
                        if (lanes_req == 4'b0000) begin
                            state_q <= DONE;
                        end else begin
                            // Strobes are registered, so the first lane is launched here.
                            state_q     <= ACCESS;
                            k_q         <= k_start;
                            pend_q      <= lanes_req & ~(4'b0001 << k_start);
                            cnt_q       <= '0;
                            sram_addr_o <= {addr_i[SRAM_AW-1:2], k_start};
                            sram_ce_n_o <= 1'b0;
                            sram_oe_n_o <= we_i;
                            sram_we_n_o <= ~we_i;
                            sram_d_oe_o <= we_i;
                            if (we_i) sram_d_o <= lane_byte(data_i, k_start);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= RECOVER;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        sram_we_n_o <= 1'b1;
                        if (!we_q) rdata_q[{k_q, 3'b000} +: 8] <= sram_d_i;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RECOVER: begin
                    if (pend_q != 4'b0000) begin
                        state_q     <= ACCESS;
                        k_q         <= k_next;
                        pend_q      <= pend_q & ~(4'b0001 << k_next);
                        cnt_q       <= '0;
                        sram_addr_o <= {word_q, k_next};
                        sram_ce_n_o <= 1'b0;
                        sram_oe_n_o <= we_q;
                        sram_we_n_o <= ~we_q;
                        if (we_q) sram_d_o <= lane_byte(wdata_q, k_next);
                    end else begin
                        state_q     <= DONE;
                        sram_d_oe_o <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_o   <= 1'b1;
                    if (!we_q) data_o <= rdata_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram8_bus_responder.sv
// Directed bench for sram8_bus_responder with a behavioural 8-bit asynchronous SRAM on the pins.
module tb_sram8_bus_responder;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        ce_i = 1'b1;
    logic        sel_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  wr_mask_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        ack_o;
    logic        overrun_o;
    logic [18:0] sram_addr;
    logic [7:0]  sram_d_i;
    logic [7:0]  sram_d_o;
    logic        sram_d_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    logic [7:0]  mem [0:255];
    logic [18:0] addr_log[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_ack = 0;
    int          n_ovr = 0;
    int          n_bad_strobe = 0;
    int          lat;

    always #5 clk = ~clk;

    sram8_bus_responder #(.SRAM_AW(19), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .reset_ni(reset_ni), .ce_i(ce_i), .sel_i(sel_i), .addr_i(addr_i),
        .we_i(we_i), .wr_mask_i(wr_mask_i), .data_i(data_i), .data_o(data_o),
        .ack_o(ack_o), .overrun_o(overrun_o), .sram_addr_o(sram_addr),
        .sram_d_i(sram_d_i), .sram_d_o(sram_d_o), .sram_d_oe_o(sram_d_oe),
        .sram_ce_n_o(sram_ce_n), .sram_oe_n_o(sram_oe_n), .sram_we_n_o(sram_we_n)
    );

    assign sram_d_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 8'h00;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] = sram_d_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one request and samples every clk after the sampling edge until ack or budget.
    task automatic xfer(input logic [31:0] addr, input logic we, input logic [3:0] mask,
                        input logic [31:0] data, input bit toggle, input int inject_at,
                        output int latency);
        addr_log.delete();
        n_ack = 0;
        n_ovr = 0;
        n_bad_strobe = 0;
        latency = -1;
        @(negedge clk);
        ce_i = 1'b1; sel_i = 1'b1; addr_i = addr; we_i = we; wr_mask_i = mask; data_i = data;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!sram_ce_n) addr_log.push_back(sram_addr);
            if (!sram_ce_n && (we ? (!sram_oe_n || !sram_d_oe) : (!sram_we_n || sram_d_oe)))
                n_bad_strobe++;
            if (overrun_o) n_ovr++;
            if (ack_o) begin
                n_ack++;
                latency = i;
                break;
            end
            @(negedge clk);
            sel_i = (i + 1 == inject_at);
            if (toggle) ce_i = ~ce_i;
        end
        if (latency < 0) $display("FAIL xfer_timeout: got no ack expected ack within 300 clk");
        @(negedge clk);
        ce_i = 1'b1; sel_i = 1'b0;
    endtask

    task automatic trail(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ack_o) n_ack++;
            if (overrun_o) n_ovr++;
        end
    endtask

    task automatic check_addrs(input string tag, input logic [18:0] base, input logic [3:0] lanes,
                               input int rep);
        logic [18:0] exp_q[$];
        for (int k = 0; k < 4; k++)
            if (lanes[k]) for (int r = 0; r < rep; r++) exp_q.push_back(base + 19'(k));
        check({tag, "_len"}, 32'(addr_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < addr_log.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(addr_log[i]), 32'(exp_q[i]));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
        mem[8'h20] = 8'h5A; mem[8'h21] = 8'h5A; mem[8'h22] = 8'h5A; mem[8'h23] = 8'h5A;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack_ovr", {30'd0, ack_o, overrun_o}, 32'd0);
        check("rst_data_o", data_o, 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_pins", {23'd0, sram_d_o, sram_d_oe}, 32'd0);
        check("rst_strobes", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        @(negedge clk);
        reset_ni = 1'b1;

        // Plain read of word 0x10.
        xfer(32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b0, -1, lat);
        check("rd_lat", 32'(lat), 32'd13);
        check("rd_data", data_o, 32'h4433_2211);
        check("rd_strobes", 32'(n_bad_strobe), 32'd0);
        check_addrs("rd_addr", 19'h10, 4'hF, 2);

        // Empty-mask write: no strobes, immediate ack, read data untouched.
        xfer(32'h0000_0010, 1'b1, 4'h0, 32'hDEAD_BEEF, 1'b0, -1, lat);
        check("wr0_lat", 32'(lat), 32'd1);
        check("wr0_strobes", 32'(addr_log.size()), 32'd0);
        check("wr0_data_o", data_o, 32'h4433_2211);
        xfer(32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b0, -1, lat);
        check("rd2_data", data_o, 32'h4433_2211);

        // Sparse write, lanes 0 and 2.
        xfer(32'h0000_0020, 1'b1, 4'b0101, 32'hAABB_CCDD, 1'b0, -1, lat);
        check("wr5_lat", 32'(lat), 32'd7);
        check("wr5_strobes", 32'(n_bad_strobe), 32'd0);
        check_addrs("wr5_addr", 19'h20, 4'b0101, 2);
        check("wr5_mem", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h5ABB_5ADD);
        check("wr5_data_o", data_o, 32'h4433_2211);

        // Single top lane write, then read back the word.
        xfer(32'h0000_0020, 1'b1, 4'b1000, 32'h7700_0000, 1'b0, -1, lat);
        check("wr8_lat", 32'(lat), 32'd4);
        xfer(32'h0000_0022, 1'b0, 4'h0, 32'h0, 1'b0, -1, lat);
        check("rd3_lat", 32'(lat), 32'd13);
        check("rd3_data", data_o, 32'h77BB_5ADD);

        // Read with ce toggling every clock: doubled timing, same pins and data.
        xfer(32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b1, -1, lat);
        check("ce_lat", 32'(lat), 32'd26);
        check("ce_data", data_o, 32'h4433_2211);
        check_addrs("ce_addr", 19'h10, 4'hF, 4);

        // sel_i during a busy read.
        xfer(32'h0000_0020, 1'b0, 4'h0, 32'h0, 1'b0, 5, lat);
        trail(6);
        check("ovr_lat", 32'(lat), 32'd13);
        check("ovr_count", 32'(n_ovr), 32'd1);
        check("ovr_acks", 32'(n_ack), 32'd1);
        check("ovr_data", data_o, 32'h77BB_5ADD);

        // Reset in the middle of a write strobe.
        @(negedge clk);
        sel_i = 1'b1; we_i = 1'b1; wr_mask_i = 4'hF; addr_i = 32'h30; data_i = 32'h0102_0304;
        @(posedge clk); #1;
        check("mid_we_low", {31'd0, sram_we_n}, 32'd0);
        #1 reset_ni = 1'b0;
        #1;
        check("mid_rst_strobes", {29'd0, sram_ce_n, sram_we_n, sram_d_oe}, 32'h6);
        check("mid_rst_data_o", data_o, 32'd0);
        @(negedge clk);
        sel_i = 1'b0;
        reset_ni = 1'b1;
        n_ack = 0;
        trail(20);
        check("mid_rst_no_ack", 32'(n_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
